// File: rtl/fft_pkg.sv
// Shared FFT types and constants.
// Sequencer state encoding lives here so benches and RTL agree.
package fft_pkg;

    localparam int SAMPLE_SIZE        = 16;
    localparam int TWIDDLE_SIZE       = 16;
    localparam int NOFLOAT_MULTIPLIER = 1 << (TWIDDLE_SIZE - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } fft_seq_state_t;

endpackage

// File: rtl/fft_sequencer_if.sv
// Sequencer bus: control handshake, sample RAM and butterfly datapath.
// master = sequencer side, slave = RAM/butterfly/host side.
interface fft_sequencer_if #(
    parameter int SAMPLE_SIZE = fft_pkg::SAMPLE_SIZE,
    parameter int LOG2N       = 3
);

    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     mem_rd_en;
    logic                     mem_wr_en;
    logic [LOG2N-1:0]         mem_addr_a;
    logic [LOG2N-1:0]         mem_addr_b;
    logic [2*SAMPLE_SIZE-1:0] mem_rd_data_a;
    logic [2*SAMPLE_SIZE-1:0] mem_rd_data_b;
    logic [2*SAMPLE_SIZE-1:0] mem_wr_data_a;
    logic [2*SAMPLE_SIZE-1:0] mem_wr_data_b;
    logic [2*SAMPLE_SIZE-1:0] bf_even;
    logic [2*SAMPLE_SIZE-1:0] bf_odd;
    logic [2*SAMPLE_SIZE-1:0] bf_sum;
    logic [2*SAMPLE_SIZE-1:0] bf_diff;
    logic [LOG2N-2:0]         tw_addr;
    logic                     bf_first_stage;

    modport master (
        input  start,
        input  mem_rd_data_a,
        input  mem_rd_data_b,
        input  bf_sum,
        input  bf_diff,
        output busy,
        output done,
        output mem_rd_en,
        output mem_wr_en,
        output mem_addr_a,
        output mem_addr_b,
        output mem_wr_data_a,
        output mem_wr_data_b,
        output bf_even,
        output bf_odd,
        output tw_addr,
        output bf_first_stage
    );

    modport slave (
        output start,
        output mem_rd_data_a,
        output mem_rd_data_b,
        output bf_sum,
        output bf_diff,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_addr_a,
        input  mem_addr_b,
        input  mem_wr_data_a,
        input  mem_wr_data_b,
        input  bf_even,
        input  bf_odd,
        input  tw_addr,
        input  bf_first_stage
    );

endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly addressing for stage s, butterfly k.
// Pure combinational; k is split around bit s to insert the span bit.
module fft_addr_gen #(
    parameter  int LOG2N = 3,
    localparam int SW    = $clog2(LOG2N),
    localparam int KW    = LOG2N - 1
) (
    input  logic [SW-1:0]    s,
    input  logic [KW-1:0]    k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [KW-1:0]    tw_addr
);

    logic [LOG2N-1:0] kw;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] lo;
    logic [SW-1:0]    sh;

    // Low s bits stay put, upper bits move up one to leave room for span.
    always_comb begin
        kw      = {1'b0, k};
        span    = LOG2N'(1) << s;
        mask    = span - 1'b1;
        lo      = kw & mask;
        sh      = SW'(LOG2N - 1) - s;
        addr_a  = ((kw & ~mask) << 1) | lo;
        addr_b  = addr_a | span;
        tw_addr = lo[KW-1:0] << sh;
    end

endmodule

// File: rtl/fft_sequencer.sv
// In-place radix-2 DIT FFT control: READ, EXEC, WRITE per butterfly.
// Butterfly arithmetic and sample RAM sit outside on the bus.
module fft_sequencer #(
    parameter int SAMPLE_SIZE  = fft_pkg::SAMPLE_SIZE,
    parameter int TWIDDLE_SIZE = fft_pkg::TWIDDLE_SIZE,
    parameter int LOG2N        = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_sequencer_if.master bus
);

    import fft_pkg::*;

    localparam int DW = 2 * SAMPLE_SIZE;
    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);

    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    if (LOG2N < 2 || LOG2N > 10 ||
        SAMPLE_SIZE < 2 || TWIDDLE_SIZE < 2) begin : g_bad_param
        $error("fft_sequencer: illegal parameters");
    end

    fft_seq_state_t   state;
    logic [SW-1:0]    s;
    logic [SW-1:0]    s_nx;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_nx;
    logic             last_bf;

    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [KW-1:0]    gen_tw;

    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;
    logic             rd_en_q;
    logic             wr_en_q;
    logic             busy_q;
    logic             done_q;
    logic             first_q;
    logic [LOG2N-1:0] addr_a_q;
    logic [LOG2N-1:0] addr_b_q;
    logic [KW-1:0]    tw_q;

    // Position of the butterfly that the next READ will fetch.
    always_comb begin
        last_bf = (k == K_LAST) && (s == S_LAST);
        s_nx    = s;
        k_nx    = k;
        if (state == WRITE) begin
            k_nx = k + 1'b1;
            if (k == K_LAST) begin
                s_nx = s + 1'b1;
            end
        end
    end

    fft_addr_gen #(
        .LOG2N   (LOG2N)
    ) u_addr (
        .s       (s_nx),
        .k       (k_nx),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_tw)
    );

    // Sequencer FSM; addresses latch on READ entry and hold to WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= '0;
            k        <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            first_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= READ;
                        busy_q   <= 1'b1;
                        rd_en_q  <= 1'b1;
                        addr_a_q <= gen_a;
                        addr_b_q <= gen_b;
                        tw_q     <= gen_tw;
                        first_q  <= (s_nx == '0);
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    state   <= WRITE;
                    op_a    <= bus.mem_rd_data_a;
                    op_b    <= bus.mem_rd_data_b;
                    wr_en_q <= 1'b1;
                end
                WRITE: begin
                    if (last_bf) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        s        <= '0;
                        k        <= '0;
                        first_q  <= 1'b0;
                        addr_a_q <= '0;
                        addr_b_q <= '0;
                        tw_q     <= '0;
                    end else begin
                        state    <= READ;
                        s        <= s_nx;
                        k        <= k_nx;
                        rd_en_q  <= 1'b1;
                        addr_a_q <= gen_a;
                        addr_b_q <= gen_b;
                        tw_q     <= gen_tw;
                        first_q  <= (s_nx == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mem_rd_en      = rd_en_q;
    assign bus.mem_wr_en      = wr_en_q;
    assign bus.mem_addr_a     = addr_a_q;
    assign bus.mem_addr_b     = addr_b_q;
    assign bus.tw_addr        = tw_q;
    assign bus.bf_first_stage = first_q;
    assign bus.bf_even        = op_a;
    assign bus.bf_odd         = op_b;
    assign bus.mem_wr_data_a  = wr_en_q ? bus.bf_sum  : '0;
    assign bus.mem_wr_data_b  = wr_en_q ? bus.bf_diff : '0;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer, N=8, with RAM and butterfly models.
// Address table, timing, impulse response, reset and start filtering.
module tb_fft_sequencer;

    import fft_pkg::*;

    localparam int SS = 16;
    localparam int LN = 3;
    localparam int NB = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic load  = 1'b0;

    fft_sequencer_if #(.SAMPLE_SIZE(SS), .LOG2N(LN)) bus ();

    fft_sequencer #(
        .SAMPLE_SIZE  (SS),
        .TWIDDLE_SIZE (TWIDDLE_SIZE),
        .LOG2N        (LN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [8];

    // Synchronous sample RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++)
                ram[i] <= (i == 0) ? 32'h03E8_0000 : 32'h0;
        end else if (bus.mem_wr_en) begin
            ram[bus.mem_addr_a] <= bus.mem_wr_data_a;
            ram[bus.mem_addr_b] <= bus.mem_wr_data_b;
        end
        if (bus.mem_rd_en) begin
            bus.mem_rd_data_a <= ram[bus.mem_addr_a];
            bus.mem_rd_data_b <= ram[bus.mem_addr_b];
        end
    end

    int ar, ai, br, bi, wr, wi, pr, pi;

    // Butterfly: a +/- W*b, W in Q14, no scaling.
    always_comb begin
        ar = $signed(bus.bf_even[31:16]);
        ai = $signed(bus.bf_even[15:0]);
        br = $signed(bus.bf_odd[31:16]);
        bi = $signed(bus.bf_odd[15:0]);
        wr = 16384;
        wi = 0;
        case (bus.tw_addr)
            2'd1:    begin wr = 11585;  wi = -11585; end
            2'd2:    begin wr = 0;      wi = -16384; end
            2'd3:    begin wr = -11585; wi = -11585; end
            default: begin wr = 16384;  wi = 0;      end
        endcase
        pr = (br * wr - bi * wi) >>> 14;
        pi = (br * wi + bi * wr) >>> 14;
        bus.bf_sum  = {16'(ar + pr), 16'(ai + pi)};
        bus.bf_diff = {16'(ar - pr), 16'(ai - pi)};
    end

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
        bit first;
    } vec_t;

    vec_t tbl [NB];
    logic [8:0] rd_rec [NB];
    logic [8:0] wr_rec [NB];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " ctl"},
            {bus.busy, bus.done, bus.mem_rd_en,
             bus.mem_wr_en, bus.bf_first_stage}, 0);
        chk({tag, " addr"},
            {bus.mem_addr_a, bus.mem_addr_b, bus.tw_addr}, 0);
        chk({tag, " data"},
            {bus.mem_wr_data_a, bus.mem_wr_data_b,
             bus.bf_even, bus.bf_odd}, 0);
    endtask

    task automatic load_impulse();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // One transform from start pulse; optional stray starts or reset.
    task automatic run_xform(input bit inject, input int rst_at,
                             input string tag);
        int busy_cnt, done_cnt, first_rd, done_at, nrd, nwr, both;
        bit aborted;
        busy_cnt = 0; done_cnt = 0; first_rd = -1; done_at = -1;
        nrd = 0; nwr = 0; both = 0; aborted = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 46; c++) begin
            if (c == rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_zero_outputs({tag, " async"});
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = c;
            end
            if (bus.mem_rd_en && bus.mem_wr_en) both++;
            if (bus.mem_rd_en) begin
                if (first_rd < 0) first_rd = c;
                if (nrd < NB)
                    rd_rec[nrd] = {bus.bf_first_stage, bus.tw_addr,
                                   bus.mem_addr_a, bus.mem_addr_b};
                nrd++;
            end
            if (bus.mem_wr_en) begin
                if (nwr < NB)
                    wr_rec[nwr] = {bus.bf_first_stage, bus.tw_addr,
                                   bus.mem_addr_a, bus.mem_addr_b};
                nwr++;
            end
            bus.start = inject && (c == 10 || c == 36);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!aborted) begin
            chk({tag, " reads"}, nrd, NB);
            chk({tag, " writes"}, nwr, NB);
            for (int i = 0; i < NB; i++) begin
                logic [8:0] e;
                e = {tbl[i].first, 2'(tbl[i].tw),
                     3'(tbl[i].a), 3'(tbl[i].b)};
                chk($sformatf("%s rd s%0d k%0d", tag, tbl[i].s, tbl[i].k),
                    rd_rec[i], e);
                chk($sformatf("%s wr s%0d k%0d", tag, tbl[i].s, tbl[i].k),
                    wr_rec[i], e);
            end
            chk({tag, " busy cycles"}, busy_cnt, 36);
            chk({tag, " done count"}, done_cnt, 1);
            chk({tag, " read-to-done"}, done_at - first_rd, 36);
            chk({tag, " rd/wr overlap"}, both, 0);
            chk({tag, " idle after"}, {bus.busy, bus.done}, 0);
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s bin%0d", tag, i), ram[i], 32'h03E8_0000);
        end
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 1, 0, 1'b1};
        tbl[1]  = '{0, 1, 2, 3, 0, 1'b1};
        tbl[2]  = '{0, 2, 4, 5, 0, 1'b1};
        tbl[3]  = '{0, 3, 6, 7, 0, 1'b1};
        tbl[4]  = '{1, 0, 0, 2, 0, 1'b0};
        tbl[5]  = '{1, 1, 1, 3, 2, 1'b0};
        tbl[6]  = '{1, 2, 4, 6, 0, 1'b0};
        tbl[7]  = '{1, 3, 5, 7, 2, 1'b0};
        tbl[8]  = '{2, 0, 0, 4, 0, 1'b0};
        tbl[9]  = '{2, 1, 1, 5, 1, 1'b0};
        tbl[10] = '{2, 2, 2, 6, 2, 1'b0};
        tbl[11] = '{2, 3, 3, 7, 3, 1'b0};

        bus.start = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        load_impulse();
        run_xform(1'b0, -1, "plain");

        load_impulse();
        run_xform(1'b1, -1, "stray start");

        load_impulse();
        run_xform(1'b0, 19, "mid reset");

        load_impulse();
        run_xform(1'b0, -1, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
